// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the execute stage.
// master = fetch unit; slave = the memory/execute environment around it.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] next_pc;
    logic        instr_valid;
    logic        ex_ack;
    logic [15:0] pc_in;
    logic        halted;
    logic        err;

    modport master (
        output imem_req, imem_addr, instr, next_pc, instr_valid, halted, err,
        input  imem_rdy, imem_data, ex_ack, pc_in
    );

    modport slave (
        input  imem_req, imem_addr, instr, next_pc, instr_valid, halted, err,
        output imem_rdy, imem_data, ex_ack, pc_in
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, fetches from a variable-latency
// memory and hands each instruction to execute, stopping on HALT or a misaligned target.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [4:0]  HALT_OP   = 5'b00000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus,
    output logic [1:0]       dbg_state
);
    // Handshakes: a memory transfer happens on a rising edge where imem_req && imem_rdy;
    // an execute transfer happens on a rising edge where instr_valid && ex_ack. imem_req,
    // imem_addr, instr and next_pc stay stable from assertion until their transfer edge.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;

    assign bus.imem_addr = pc;
    assign dbg_state     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            bus.imem_req    <= 1'b0;
            bus.instr       <= NOP_INSTR;
            bus.next_pc     <= RESET_PC;
            bus.instr_valid <= 1'b0;
            bus.halted      <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= REQ;
                    bus.imem_req <= 1'b1;
                end
                REQ: begin
                    if (bus.imem_rdy) begin
                        bus.instr       <= bus.imem_data;
                        bus.next_pc     <= pc + 16'd2;
                        bus.imem_req    <= 1'b0;
                        bus.instr_valid <= 1'b1;
                        state           <= VALID;
                    end
                end
                VALID: begin
                    if (bus.ex_ack) begin
                        bus.instr_valid <= 1'b0;
                        // HALT wins over a misaligned target, so err stays clear then.
                        if (bus.instr[15:11] == HALT_OP) begin
                            bus.halted <= 1'b1;
                            bus.instr  <= NOP_INSTR;
                            state      <= HALTED;
                        end else if (bus.pc_in[0]) begin
                            bus.err    <= 1'b1;
                            bus.halted <= 1'b1;
                            bus.instr  <= NOP_INSTR;
                            state      <= HALTED;
                        end else begin
                            pc           <= bus.pc_in;
                            bus.imem_req <= 1'b1;
                            state        <= REQ;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the PC,
// halt and error state; a second instance covers the PC wrap at 16'hFFFE.
module tb_fetch_unit;
    localparam logic [15:0] RST_PC   = 16'h0000;
    localparam logic [15:0] W_RST_PC = 16'hFFFE;
    localparam logic [4:0]  HALT     = 5'b00000;
    localparam logic [15:0] NOP      = 16'h0800;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [1:0] w_dbg_state;

    fetch_unit_if bus ();
    fetch_unit_if w_bus ();

    fetch_unit #(.RESET_PC(RST_PC), .HALT_OP(HALT), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    fetch_unit #(.RESET_PC(W_RST_PC), .HALT_OP(HALT), .NOP_INSTR(NOP)) w_dut (
        .clk(clk), .rst(rst), .bus(w_bus), .dbg_state(w_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_err;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_req",     bus.imem_req,    1'b0);
        check_val("rst_addr",    bus.imem_addr,   RST_PC);
        check_val("rst_instr",   bus.instr,       NOP);
        check_val("rst_next_pc", bus.next_pc,     RST_PC);
        check_val("rst_valid",   bus.instr_valid, 1'b0);
        check_val("rst_halted",  bus.halted,      1'b0);
        check_val("rst_err",     bus.err,         1'b0);
        rst = 1'b0;
        m_pc     = RST_PC;
        m_halted = 1'b0;
        m_err    = 1'b0;
        @(negedge clk);
        check_val("req_after_reset", bus.imem_req, 1'b1);
    endtask

    // One fetch transaction: waits memory stalls, hold cycles before ack, then ack with target.
    task automatic fetch_one(input int waits, input int hold,
                             input logic [15:0] data, input logic [15:0] target);
        int n;
        logic [15:0] exp_np;
        n = 0;
        while (!bus.imem_req && n < 6) begin
            @(negedge clk);
            n++;
        end
        check_val("req_latency", n[15:0], 16'd0);
        check_val("req_addr", bus.imem_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            bus.imem_rdy  = 1'b0;
            bus.imem_data = 16'($urandom);
            bus.ex_ack    = 1'($urandom_range(0, 1));
            bus.pc_in     = 16'($urandom);
            @(negedge clk);
            check_val("wait_req",   bus.imem_req,    1'b1);
            check_val("wait_addr",  bus.imem_addr,   m_pc);
            check_val("wait_valid", bus.instr_valid, 1'b0);
        end
        bus.ex_ack    = 1'b0;
        bus.imem_rdy  = 1'b1;
        bus.imem_data = data;
        @(negedge clk);
        bus.imem_rdy  = 1'b0;
        bus.imem_data = 16'($urandom);
        exp_np = m_pc + 16'd2;
        check_val("valid",   bus.instr_valid, 1'b1);
        check_val("instr",   bus.instr,       data);
        check_val("next_pc", bus.next_pc,     exp_np);
        check_val("req_off", bus.imem_req,    1'b0);
        for (int i = 0; i < hold; i++) begin
            bus.ex_ack = 1'b0;
            bus.pc_in  = 16'($urandom);
            bus.imem_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("hold_valid",   bus.instr_valid, 1'b1);
            check_val("hold_instr",   bus.instr,       data);
            check_val("hold_next_pc", bus.next_pc,     exp_np);
        end
        bus.imem_rdy = 1'b0;
        bus.ex_ack   = 1'b1;
        bus.pc_in    = target;
        @(negedge clk);
        bus.ex_ack = 1'b0;
        if (data[15:11] == HALT) m_halted = 1'b1;
        else if (target[0]) begin
            m_err    = 1'b1;
            m_halted = 1'b1;
        end else m_pc = target;
        check_val("ack_halted", bus.halted,      m_halted);
        check_val("ack_err",    bus.err,         m_err);
        check_val("ack_valid",  bus.instr_valid, 1'b0);
        check_val("ack_req",    bus.imem_req,    !m_halted);
        check_val("ack_addr",   bus.imem_addr,   m_pc);
    endtask

    task automatic check_halted_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_rdy  = 1'($urandom_range(0, 1));
            bus.imem_data = 16'($urandom);
            bus.ex_ack    = 1'($urandom_range(0, 1));
            bus.pc_in     = 16'($urandom);
            @(negedge clk);
            check_val("halt_req",    bus.imem_req,    1'b0);
            check_val("halt_flag",   bus.halted,      1'b1);
            check_val("halt_valid",  bus.instr_valid, 1'b0);
            check_val("halt_instr",  bus.instr,       NOP);
            check_val("halt_addr",   bus.imem_addr,   m_pc);
            check_val("halt_err",    bus.err,         m_err);
        end
        bus.imem_rdy = 1'b0;
        bus.ex_ack   = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] d;
        d = 16'($urandom);
        if (d[15:11] == HALT) d[15:11] = 5'd1;
        return d;
    endfunction

    function automatic logic [15:0] rand_even();
        logic [15:0] t;
        t = 16'($urandom);
        t[0] = 1'b0;
        return t;
    endfunction

    initial begin
        logic [15:0] tgt;
        logic [15:0] w_exp;
        rst = 1'b1;
        bus.imem_rdy = 1'b0;  bus.imem_data = 16'h0;  bus.ex_ack = 1'b0;  bus.pc_in = 16'h0;
        w_bus.imem_rdy = 1'b0; w_bus.imem_data = 16'h0; w_bus.ex_ack = 1'b0; w_bus.pc_in = 16'h0;
        #3;
        check_val("async_rst_req", bus.imem_req, 1'b0);

        // zero-wait fetch, sequential ack, then 3-wait fetch held for 5 cycles
        do_reset();
        fetch_one(0, 0, 16'h4123, 16'h0002);
        fetch_one(3, 5, rand_instr(), 16'h0010);
        // branch redirect from 0x0010 to 0x0040
        fetch_one(1, 0, rand_instr(), 16'h0040);
        fetch_one(0, 1, rand_instr(), 16'h0044);

        // randomized traffic
        for (int k = 0; k < 30; k++) begin
            tgt = ($urandom_range(0, 1) != 0) ? (m_pc + 16'd2) : rand_even();
            fetch_one($urandom_range(0, 4), $urandom_range(0, 3), rand_instr(), tgt);
        end

        // HALT with a misaligned target: halt wins, err stays 0
        do_reset();
        fetch_one(0, 0, rand_instr(), 16'h0020);
        fetch_one($urandom_range(0, 2), 1, {HALT, 11'($urandom)}, 16'h0031);
        check_halted_idle(20);

        // misaligned target on a normal instruction
        do_reset();
        fetch_one(2, 0, rand_instr(), 16'h0030);
        fetch_one(0, 2, rand_instr(), 16'h0031);
        check_halted_idle(5);

        // reset mid-REQ with imem_rdy low
        do_reset();
        fetch_one(0, 0, rand_instr(), 16'h0100);
        bus.imem_rdy = 1'b0;
        @(posedge clk);
        #2;
        check_val("pre_rst_req", bus.imem_req, 1'b1);
        rst = 1'b1;
        #1;
        check_val("mid_req_rst_req",  bus.imem_req,  1'b0);
        check_val("mid_req_rst_addr", bus.imem_addr, RST_PC);
        do_reset();
        fetch_one(1, 0, rand_instr(), 16'h0002);

        // wrap instance: reset PC 16'hFFFE, next_pc wraps to 0
        do_reset();
        w_exp = W_RST_PC + 16'd2;
        check_val("w_req",  w_bus.imem_req,  1'b1);
        check_val("w_addr", w_bus.imem_addr, W_RST_PC);
        w_bus.imem_rdy  = 1'b1;
        w_bus.imem_data = 16'h4123;
        @(negedge clk);
        w_bus.imem_rdy = 1'b0;
        check_val("w_valid",   w_bus.instr_valid, 1'b1);
        check_val("w_instr",   w_bus.instr,       16'h4123);
        check_val("w_next_pc", w_bus.next_pc,     w_exp);
        w_bus.ex_ack = 1'b1;
        w_bus.pc_in  = 16'h0000;
        @(negedge clk);
        w_bus.ex_ack = 1'b0;
        check_val("w_req2",  w_bus.imem_req,  1'b1);
        check_val("w_addr2", w_bus.imem_addr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
